obstacle_feeder: RTL
====================

# obstacle_feeder

- Upstream stage of the 6-bit playfield shift register.
- Produces the one-cycle `Shift` strobe and the `BitIn` obstacle bit that scroll the playfield on each game tick.
- Contains:
  - a programmable tick divider whose period shrinks as the game progresses;
  - an 8-bit LFSR obstacle generator with an enforced minimum gap between obstacles;
  - a small IDLE/RUN/HALT controller driven by the game's `Run` and `GameOver` signals.

## Interface
Parameters:
- `TICK_W`, 26 — width of the tick counter and of the period register.
- `INIT_PERIOD`, 25000000 — tick period in Clk cycles at level 0. Must be ≥ 2.
- `MIN_PERIOD`, 5000000 — floor for the period. Must satisfy 2 ≤ `MIN_PERIOD` ≤ `INIT_PERIOD`.
- `SPEED_STEP`, 1250000 — period decrement applied every 16 shifts.
- `DENSITY`, 3 — an obstacle candidate is emitted when `lfsr[2:0] < DENSITY`. Range 0..8.
- `MIN_GAP`, 2 — number of forced-empty shifts after every obstacle.
- `START_GAP`, 6 — number of forced-empty shifts after reset.
- `LFSR_SEED`, 8'hA5 — LFSR reset value. A seed of 0 is replaced by 8'h01.

Ports:
- `Clk` — input, 1 — system clock.
- `Rst` — input, 1 — reset, synchronous, active-low.
- `Run` — input, 1 — 1 = game running; 0 = paused.
- `GameOver` — input, 1 — level-sensitive collision flag. Once seen, the block latches HALT until reset.
- `Shift` — output, 1 — one-cycle strobe. Drives the shift register's `Shift` input.
- `BitIn` — output, 1 — obstacle bit. Valid whenever `Shift`=1 and held between strobes.
- `Level` — output, 4 — speed level, 0..15, saturating.
- `Halted` — output, 1 — 1 while the controller is in HALT.

## Operation
- Controller states and transitions:
  - IDLE → RUN when `Run`=1.
  - RUN → IDLE when `Run`=0.
  - IDLE or RUN → HALT when `GameOver`=1.
  - HALT is left only by reset.
  - `GameOver` has priority over `Run`.
- Qualifying edge: any clock edge where `Rst`=1, `Run`=1, `GameOver`=0 and the state is not HALT.
- Tick counter:
  - Decrements on every qualifying edge.
  - On a qualifying edge with counter == 0: counter ← period−1, and `Shift` ← 1.
  - `Shift` ← 0 on every other edge.
  - Pausing holds the counter; counting resumes from the held value.
- On each shift:
  - The LFSR advances one step. It is an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left, feedback = b7^b5^b4^b3 into b0.
  - `candidate` = (new `lfsr[2:0]` < `DENSITY`).
  - If `gap` ≠ 0: `BitIn` ← 0 and `gap` ← `gap`−1.
  - Else if `candidate`: `BitIn` ← 1 and `gap` ← `MIN_GAP`.
  - Else: `BitIn` ← 0.
- Speed-up:
  - A 4-bit shift count increments on each shift.
  - On wrap 15→0: period ← max(period−`SPEED_STEP`, `MIN_PERIOD`), and `Level` ← min(`Level`+1, 15).
  - The reload on the wrap edge uses the old period; the new period applies from the next reload.
  - The subtraction is done at `TICK_W`+1 bits so it never underflows.
- Reset values:
  - Outputs: `Shift`=0, `BitIn`=0, `Level`=0, `Halted`=0.
  - Internal: state = IDLE, period = `INIT_PERIOD`, counter = `INIT_PERIOD`−1, `gap` = `START_GAP`, shift count = 0, LFSR = seed.
- Reset applied mid-game, including from HALT, restores all of the above on the next edge; any pending `Shift` is dropped.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- With `Run`=1 held from the first cycle after reset, the first `Shift` is high in the cycle after the `INIT_PERIOD`-th qualifying edge. It then repeats every `period` cycles.
- `Shift` is high for exactly 1 cycle.
- `BitIn` changes only on the same edge that raises `Shift`.
- `GameOver` and the terminal count on the same edge: no `Shift`; HALT is entered. `Halted`=1 from the next cycle.
- `Run` falling on the terminal-count edge: that edge is not qualifying, so no `Shift`; the counter stays at 0 and fires on the first qualifying edge after resume.
- `Level` and the period update on the same edge as the 16th `Shift`.

## Structure
- Shared package `segrun_pkg` holds:
  - the state enum (IDLE, RUN, HALT);
  - the LFSR tap constant;
  - `LEVEL_W`=4.
- Sub-module `lfsr8`, with ports Clk, Rst, Step, Seed, Q[7:0]. It handles the zero-seed substitution.
- The rest is flat: controller, tick counter, period/level logic, gap logic.

## Test plan
Bench parameters: `INIT_PERIOD`=4, `MIN_PERIOD`=2, `SPEED_STEP`=1, `START_GAP`=6, `MIN_GAP`=2, `DENSITY`=8.
- Reset then `Run`=1 → `Shift` pulses at cycles 5, 9, 13, … (1-cycle each). The first 6 `BitIn`=0, the 7th `BitIn`=1, then 0,0,1 repeating.
- Run 16 shifts → `Level`=1; the 17th shift follows 4 cycles after the 16th, the 18th 3 cycles after the 17th. After 48 shifts the period is clamped at 2, and `Level` saturates at 15 after 240 shifts.
- Drop `Run` for 10 cycles, 2 cycles into a period → no `Shift` while paused; the next `Shift` comes 2 qualifying cycles after resume.
- Assert `GameOver` on a terminal-count edge → no `Shift`, `Halted`=1 next cycle. `Run`=1 afterwards keeps `Shift`=0 forever.
- `Rst`=0 for 1 cycle while HALT with `Level`=3 → all outputs back to reset values; the sequence of the first scenario repeats exactly.
- `DENSITY`=0 → `BitIn` is never 1 over 100 shifts. `LFSR_SEED`=0 → LFSR is non-zero after reset (8'h01).

Source files
------------

// File: rtl/segrun_pkg.sv
// Shared types and constants for the segment-runner game blocks.
package segrun_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int LEVEL_W = 4;

  // Taps b7, b5, b4, b3 for x^8+x^6+x^5+x^4+1, Fibonacci form shifting left.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that advances one step per Step strobe.
module lfsr8
  import segrun_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Step,
  input  logic [7:0] Seed,
  output logic [7:0] Q
);

  // An all-zero state would lock the LFSR, so a zero seed loads 8'h01.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Q <= (Seed == 8'h00) ? 8'h01 : Seed;
    end else if (Step) begin
      Q <= lfsr_next(Q);
    end
  end

endmodule

// File: rtl/obstacle_feeder.sv
// Tick divider, obstacle generator and run/halt controller feeding the
// playfield shift register with a Shift strobe and an obstacle bit.
module obstacle_feeder
  import segrun_pkg::*;
#(
  parameter int         TICK_W      = 26,
  parameter int         INIT_PERIOD = 25000000,
  parameter int         MIN_PERIOD  = 5000000,
  parameter int         SPEED_STEP  = 1250000,
  parameter int         DENSITY     = 3,
  parameter int         MIN_GAP     = 2,
  parameter int         START_GAP   = 6,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Run,
  input  logic               GameOver,
  output logic               Shift,
  output logic               BitIn,
  output logic [LEVEL_W-1:0] Level,
  output logic               Halted
);

  localparam int GAP_MAX = (MIN_GAP > START_GAP) ? MIN_GAP : START_GAP;
  localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [TICK_W-1:0]  ONE_T     = TICK_W'(1);
  localparam logic [TICK_W:0]    STEP_X    = (TICK_W + 1)'(SPEED_STEP);
  localparam logic [TICK_W:0]    MIN_X     = (TICK_W + 1)'(MIN_PERIOD);
  localparam logic [3:0]         DENSITY_L = 4'(DENSITY);
  localparam logic [GAP_W-1:0]   ONE_G     = GAP_W'(1);
  localparam logic [LEVEL_W-1:0] ONE_L     = LEVEL_W'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [TICK_W-1:0]    r_count;
  logic [TICK_W-1:0]    r_period;
  logic [GAP_W-1:0]     r_gap;
  logic [3:0]           r_shift_cnt;
  logic [LEVEL_W-1:0]   r_level;
  logic                 r_shift;
  logic                 r_bit_in;

  logic                 w_qual;
  logic                 w_fire;
  logic                 w_candidate;
  logic [7:0]           w_lfsr_q;
  logic [7:0]           w_lfsr_next;
  logic [TICK_W:0]      w_period_dec;
  logic [TICK_W-1:0]    w_period_new;

  // A qualifying edge needs Run high, no collision and a live controller.
  assign w_qual      = Run && !GameOver && (r_state != HALT);
  assign w_fire      = w_qual && (r_count == '0);
  assign w_lfsr_next = lfsr_next(w_lfsr_q);
  assign w_candidate = ({1'b0, w_lfsr_next[2:0]} < DENSITY_L);

  // The extra top bit is a borrow flag: set means the step overshot zero.
  assign w_period_dec = {1'b0, r_period} - STEP_X;
  assign w_period_new = (w_period_dec[TICK_W] || (w_period_dec < MIN_X))
                        ? MIN_X[TICK_W-1:0] : w_period_dec[TICK_W-1:0];

  lfsr8 u_lfsr (
    .Clk  (Clk),
    .Rst  (Rst),
    .Step (w_fire),
    .Seed (LFSR_SEED),
    .Q    (w_lfsr_q)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: default first so every path assigns w_state_next and no latch forms.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (GameOver) w_state_next = HALT;
               else if (Run) w_state_next = RUN;
      RUN:     if (GameOver) w_state_next = HALT;
               else if (!Run) w_state_next = IDLE;
      HALT:    w_state_next = HALT;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking updates let the wrap edge reload from the old period.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count     <= TICK_W'(INIT_PERIOD - 1);
      r_period    <= TICK_W'(INIT_PERIOD);
      r_gap       <= GAP_W'(START_GAP);
      r_shift_cnt <= '0;
      r_level     <= '0;
      r_shift     <= 1'b0;
      r_bit_in    <= 1'b0;
    end else begin
      r_shift <= w_fire;
      if (w_qual) begin
        r_count <= w_fire ? (r_period - ONE_T) : (r_count - ONE_T);
      end
      if (w_fire) begin
        if (r_gap != '0) begin
          r_bit_in <= 1'b0;
          r_gap    <= r_gap - ONE_G;
        end else if (w_candidate) begin
          r_bit_in <= 1'b1;
          r_gap    <= GAP_W'(MIN_GAP);
        end else begin
          r_bit_in <= 1'b0;
        end
        r_shift_cnt <= r_shift_cnt + 4'd1;
        if (r_shift_cnt == 4'hF) begin
          r_period <= w_period_new;
          if (r_level != '1) begin
            r_level <= r_level + ONE_L;
          end
        end
      end
    end
  end

  assign Shift  = r_shift;
  assign BitIn  = r_bit_in;
  assign Level  = r_level;
  assign Halted = (r_state == HALT);

endmodule
